// File: rtl/irem_pkg.sv
// Shared types and parameter defaults for the Irem INTA sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Optional IREM_INTA_TIMEOUT_EN build enables the second-INTA watchdog.
package irem_pkg;

    localparam int ACK_WIDTH_DEF      = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        WAIT1,
        ARM2,
        ACK2,
        DONE
    } irem_state_t;

endpackage

// File: rtl/irem_ack_pulse.sv
// PIC acknowledge pulse: ACK_WIDTH ce-cycles high, ACK_WIDTH low, then a done strobe.
// Latency: ack rises on the start ce-cycle; done is seen 2*ACK_WIDTH ce-cycles later.
// Backpressure: none; start is ignored while a pulse is in flight, all timing holds on ce=0.
module irem_ack_pulse
    import irem_pkg::*;
#(
    parameter int ACK_WIDTH = ACK_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic start,
    output logic ack,
    output logic done
);

    localparam int CW = $clog2(2 * ACK_WIDTH) + 1;
    localparam logic [CW-1:0] HI_LAST = CW'(ACK_WIDTH - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(2 * ACK_WIDTH - 1);

    logic          busy;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            ack  <= 1'b0;
        end else if (ce) begin
            if (start && !busy) begin
                busy <= 1'b1;
                cnt  <= '0;
                ack  <= 1'b1;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
                if (cnt == HI_LAST) ack <= 1'b0;
                if (cnt == LO_LAST) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                end
            end
        end
    end

    // Strobe covers the final low ce-cycle so the sequencer acts on the same edge.
    assign done = ce && busy && (cnt == LO_LAST);

endmodule

// File: rtl/irem_inta_seq.sv
// Bridges a PIC request into the CPU's two-INTA handshake, pulsing the PIC ack once per INTA.
// Latency: cpu_intr one ce-cycle after request; cpu_ready 2*ACK_WIDTH+1 ce-cycles after each INTA rise.
// Backpressure: cpu_ready holds the INTA cycle; IREM_INTA_TIMEOUT_EN adds a missed-second-INTA watchdog.
module irem_inta_seq
    import irem_pkg::*;
#(
    parameter int ACK_WIDTH      = ACK_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       pic_int_req,
    input  logic [7:0] pic_vector,
    output logic       pic_int_ack,
    output logic       cpu_intr,
    input  logic       cpu_inta,
    output logic [7:0] cpu_vector,
    output logic       cpu_ready,
    output logic       timeout_flag
);

    if (ACK_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("irem_inta_seq: ACK_WIDTH and TIMEOUT_CYCLES must be >= 1");
    end

    irem_state_t state, state_nxt;
    logic        inta_q, inta_rise;
    logic        intr_nxt, ready_nxt;
    logic [7:0]  vec_nxt;
    logic        pulse_start, pulse_done;

    assign inta_rise = cpu_inta & ~inta_q;

`ifdef IREM_INTA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic          to_pend, to_pend_nxt, tflag_nxt, to_hit;
    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_flag = 1'b0;
`endif

    irem_ack_pulse #(.ACK_WIDTH(ACK_WIDTH)) u_ack_pulse (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (pulse_start),
        .ack   (pic_int_ack),
        .done  (pulse_done)
    );

    always_comb begin
        state_nxt   = state;
        intr_nxt    = cpu_intr;
        ready_nxt   = cpu_ready;
        vec_nxt     = cpu_vector;
        pulse_start = 1'b0;
`ifdef IREM_INTA_TIMEOUT_EN
        to_cnt_nxt  = '0;
        to_pend_nxt = to_pend;
        tflag_nxt   = timeout_flag;
`endif
        case (state)
            IDLE: if (pic_int_req) begin
                state_nxt = REQ;
                intr_nxt  = 1'b1;
            end
            REQ: begin
                if (inta_rise) begin
                    state_nxt   = ACK1;
                    intr_nxt    = 1'b0;
                    pulse_start = 1'b1;
                end else if (!pic_int_req) begin
                    state_nxt = IDLE;
                    intr_nxt  = 1'b0;
                end
            end
            // From here on the request line is ignored: the PIC is committed to two acks.
            ACK1: if (pulse_done) begin
                vec_nxt   = pic_vector;
                ready_nxt = 1'b1;
                state_nxt = WAIT1;
            end
            WAIT1: if (!cpu_inta) begin
                ready_nxt = 1'b0;
                state_nxt = ARM2;
            end
            ARM2: begin
                if (inta_rise) begin
                    state_nxt   = ACK2;
                    pulse_start = 1'b1;
                end
`ifdef IREM_INTA_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt   = ACK2;
                    pulse_start = 1'b1;
                    to_pend_nxt = 1'b1;
                    tflag_nxt   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
`endif
            end
            ACK2: if (pulse_done) begin
                state_nxt = DONE;
                ready_nxt = 1'b1;
`ifdef IREM_INTA_TIMEOUT_EN
                if (to_pend) begin
                    state_nxt   = IDLE;
                    ready_nxt   = 1'b0;
                    to_pend_nxt = 1'b0;
                end
`endif
            end
            DONE: if (!cpu_inta) begin
                ready_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cpu_intr     <= 1'b0;
            cpu_ready    <= 1'b0;
            cpu_vector   <= 8'h00;
            inta_q       <= 1'b0;
`ifdef IREM_INTA_TIMEOUT_EN
            to_cnt       <= '0;
            to_pend      <= 1'b0;
            timeout_flag <= 1'b0;
`endif
        end else if (ce) begin
            state        <= state_nxt;
            cpu_intr     <= intr_nxt;
            cpu_ready    <= ready_nxt;
            cpu_vector   <= vec_nxt;
            inta_q       <= cpu_inta;
`ifdef IREM_INTA_TIMEOUT_EN
            to_cnt       <= to_cnt_nxt;
            to_pend      <= to_pend_nxt;
            timeout_flag <= tflag_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_irem_inta_seq.sv
// Self-checking bench for irem_inta_seq: directed scenarios with randomized vectors, delays and ce gating.
// Expected behaviour is derived per ce-cycle from the handshake rules; IREM_INTA_TIMEOUT_EN adds the watchdog case.
module tb_irem_inta_seq;

    localparam int W  = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset, ce, pic_int_req, cpu_inta;
    logic [7:0] pic_vector;
    logic       pic_int_ack, cpu_intr, cpu_ready, timeout_flag;
    logic [7:0] cpu_vector;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         pulses   = 0;
    int         gate     = 0;
    logic       ack_prev = 1'b0;
    logic [7:0] exp_vec  = 8'h00;
    logic       exp_tflag = 1'b0;

    always #5 clk = ~clk;

    irem_inta_seq #(.ACK_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .pic_int_req  (pic_int_req),
        .pic_vector   (pic_vector),
        .pic_int_ack  (pic_int_ack),
        .cpu_intr     (cpu_intr),
        .cpu_inta     (cpu_inta),
        .cpu_vector   (cpu_vector),
        .cpu_ready    (cpu_ready),
        .timeout_flag (timeout_flag)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic c);
        @(negedge clk);
        ce = c;
        @(posedge clk);
        #1;
        if (pic_int_ack && !ack_prev) pulses++;
        ack_prev = pic_int_ack;
    endtask

    // One ce-qualified cycle, preceded by ce=0 cycles during which every output must hold.
    task automatic cyc();
        int          n;
        logic [11:0] snap;
        n = (gate == 1) ? 2 : (gate == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            snap = {cpu_intr, pic_int_ack, cpu_ready, timeout_flag, cpu_vector};
            tick(1'b0);
            chk("ce_hold", {cpu_intr, pic_int_ack, cpu_ready, timeout_flag, cpu_vector}, snap);
        end
        tick(1'b1);
        chk("tflag", timeout_flag, exp_tflag);
    endtask

    task automatic outs(input string tag, input logic intr, input logic ack, input logic rdy);
        chk({tag, "_intr"}, cpu_intr, intr);
        chk({tag, "_ack"}, pic_int_ack, ack);
        chk({tag, "_rdy"}, cpu_ready, rdy);
    endtask

    // Remainder of an ack pulse after its first high ce-cycle: W-1 high, W low, no ready.
    task automatic pulse_rest(input string tag);
        repeat (W - 1) begin cyc(); outs({tag, "_hi"}, 1'b0, 1'b1, 1'b0); end
        repeat (W)     begin cyc(); outs({tag, "_lo"}, 1'b0, 1'b0, 1'b0); end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pic_int_req = 1'b0;
        cpu_inta    = 1'b0;
        #1;
        outs("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_vec", cpu_vector, 8'h00);
        chk("rst_tflag", timeout_flag, 1'b0);
        exp_vec   = 8'h00;
        exp_tflag = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        ack_prev = 1'b0;
    endtask

    // mode 0: full two-INTA service; 1: reset during ACK2; 2: second INTA never arrives.
    task automatic seq(input logic [7:0] vec, input bit late_drop, input bit keep_req, input int mode);
        int d, p0;
        p0          = pulses;
        pic_int_req = 1'b1;
        pic_vector  = 8'($urandom);
        cpu_inta    = 1'b0;
        cyc(); outs("req", 1'b1, 1'b0, 1'b0);
        chk("vec_prev", cpu_vector, exp_vec);
        d = $urandom_range(0, 3);
        repeat (d) begin cyc(); outs("req_wait", 1'b1, 1'b0, 1'b0); end

        cpu_inta = 1'b1;
        cyc(); outs("ack1_rise", 1'b0, 1'b1, 1'b0);
        pic_vector = vec;
        if (late_drop) pic_int_req = 1'b0;
        pulse_rest("ack1");
        cyc(); outs("rdy1", 1'b0, 1'b0, 1'b1);
        exp_vec = vec;
        chk("vec1", cpu_vector, exp_vec);
        pic_vector = 8'($urandom);
        d = $urandom_range(0, 3);
        repeat (d) begin cyc(); outs("wait1", 1'b0, 1'b0, 1'b1); chk("vec1_hold", cpu_vector, exp_vec); end

        cpu_inta = 1'b0;
        cyc(); outs("arm2", 1'b0, 1'b0, 1'b0);
        if (mode == 2) begin
            pic_int_req = 1'b0;
            repeat (TO - 1) begin cyc(); outs("arm2_to", 1'b0, 1'b0, 1'b0); end
            exp_tflag = 1'b1;
            cyc(); outs("to_ack", 1'b0, 1'b1, 1'b0);
            pulse_rest("ack2_to");
            cyc(); outs("to_idle", 1'b0, 1'b0, 1'b0);
            cyc(); outs("to_idle2", 1'b0, 1'b0, 1'b0);
            chk("to_vec", cpu_vector, exp_vec);
            chk("to_pulses", pulses - p0, 2);
        end else begin
            d = $urandom_range(0, 5);
            repeat (d) begin cyc(); outs("arm2_gap", 1'b0, 1'b0, 1'b0); end
            cpu_inta = 1'b1;
            cyc(); outs("ack2_rise", 1'b0, 1'b1, 1'b0);
            if (mode == 1) begin
                chk("mid_pulses", pulses - p0, 2);
                #2;
                do_reset();
            end else begin
                pulse_rest("ack2");
                cyc(); outs("rdy2", 1'b0, 1'b0, 1'b1);
                chk("vec2", cpu_vector, exp_vec);
                d = $urandom_range(0, 3);
                repeat (d) begin cyc(); outs("done_hold", 1'b0, 1'b0, 1'b1); end
                cpu_inta = 1'b0;
                if (!keep_req) pic_int_req = 1'b0;
                cyc(); outs("done_idle", 1'b0, 1'b0, 1'b0);
                chk("vec2_hold", cpu_vector, exp_vec);
                chk("pulses", pulses - p0, 2);
                if (!pic_int_req) begin cyc(); outs("idle", 1'b0, 1'b0, 1'b0); end
            end
        end
    endtask

    task automatic spurious();
        int d, p0;
        p0          = pulses;
        pic_int_req = 1'b1;
        cpu_inta    = 1'b0;
        cyc(); outs("spur_req", 1'b1, 1'b0, 1'b0);
        d = $urandom_range(0, 3);
        repeat (d) begin cyc(); outs("spur_wait", 1'b1, 1'b0, 1'b0); end
        pic_int_req = 1'b0;
        cyc(); outs("spur_drop", 1'b0, 1'b0, 1'b0);
        cpu_inta = 1'b1;
        repeat (3) begin cyc(); outs("idle_inta", 1'b0, 1'b0, 1'b0); end
        cpu_inta = 1'b0;
        cyc(); outs("spur_end", 1'b0, 1'b0, 1'b0);
        chk("spur_pulses", pulses - p0, 0);
    endtask

    initial begin
        ce          = 1'b0;
        pic_vector  = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();

        gate = 0;
        seq(8'h45, 1'b0, 1'b0, 0);
        spurious();
        seq(8'hA7, 1'b1, 1'b0, 0);

        gate = 1;
        seq(8'h45, 1'b0, 1'b0, 0);

        gate = 2;
        for (int i = 0; i < 8; i++) begin
            seq(8'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        spurious();

        gate = 0;
        seq(8'h3C, 1'b0, 1'b0, 1);
        seq(8'h45, 1'b0, 1'b0, 0);

`ifdef IREM_INTA_TIMEOUT_EN
        seq(8'h5A, 1'b0, 1'b0, 2);
        gate = 2;
        seq(8'hC3, 1'b0, 1'b0, 0);
        gate = 0;
        @(posedge clk);
        #2;
        do_reset();
        seq(8'h11, 1'b0, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/irem_inta_seq.md
IREM_INTA_SEQ -- requirements
Module: irem_inta_seq

Interface
REQ-001 Parameter ACK_WIDTH, 2, number of ce-qualified cycles each pic_int_ack pulse stays high and the minimum number it stays low after each pulse.
REQ-002 Parameter TIMEOUT_CYCLES, 1024, ce-qualified cycle limit for the CPU to start its second INTA cycle (used only with IREM_INTA_TIMEOUT_EN).
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ce  input  1  clock enable; all state advances only on ce=1.
REQ-006 pic_int_req  input  1  pending unmasked interrupt from the PIC.
REQ-007 pic_vector  input  8  vector driven by the PIC, valid after the first acknowledge.
REQ-008 pic_int_ack  output  1  acknowledge pulse to the PIC.
REQ-009 cpu_intr  output  1  interrupt request to the CPU.
REQ-010 cpu_inta  input  1  high while the CPU runs an INTA bus cycle; each INTA is one high period.
REQ-011 cpu_vector  output  8  vector returned to the CPU.
REQ-012 cpu_ready  output  1  INTA cycle may complete; cpu_vector is valid when cpu_inta is high.
REQ-013 timeout_flag  output  1  sticky; second INTA was missed.

Function
REQ-014 States SHALL be IDLE, REQ, ACK1, WAIT1, ARM2, ACK2, DONE.
REQ-015 In IDLE, pic_int_req=1 SHALL move the block to REQ and assert cpu_intr on the next ce cycle.
REQ-016 In REQ, a pic_int_req drop before cpu_inta rises SHALL return the block to IDLE and deassert cpu_intr with no ack (spurious request).
REQ-017 In REQ, a cpu_inta rising edge SHALL move the block to ACK1, drop cpu_intr, and drive pic_int_ack high for ACK_WIDTH ce cycles.
REQ-018 After the ACK1 high phase, pic_int_ack SHALL be held low for ACK_WIDTH ce cycles, after which pic_vector is latched into cpu_vector.
REQ-019 cpu_ready SHALL then assert and the block SHALL enter WAIT1.
REQ-020 WAIT1 SHALL persist until cpu_inta falls; cpu_ready SHALL drop on that fall; the block then enters ARM2.
REQ-021 In ARM2, a cpu_inta rising edge SHALL move the block to ACK2, which issues a second pulse with the same width rules as ACK1.
REQ-022 cpu_ready SHALL assert after the ACK2 low phase, with cpu_vector unchanged.
REQ-023 On entering DONE, the block SHALL wait for cpu_inta to fall, then drop cpu_ready and go to IDLE.
REQ-024 After ACK1 is issued, a pic_int_req drop SHALL be ignored; the latched vector is still returned and the second ack is still issued.
REQ-025 Minimum IDLE->IDLE turnaround SHALL be one ce cycle in IDLE before a new REQ is accepted, so back-to-back interrupts are serviced sequentially.
REQ-026 cpu_inta high while in IDLE SHALL be ignored, and cpu_ready SHALL stay 0.
REQ-027 With ce=0, all outputs and counters SHALL hold.

Reset
REQ-028 Reset SHALL force state to IDLE.
REQ-029 Reset SHALL set cpu_intr=0, pic_int_ack=0, cpu_ready=0, cpu_vector=8'h00, timeout_flag=0, and all counters to 0, including mid-sequence.

Configuration
REQ-030 With IREM_INTA_TIMEOUT_EN defined, a counter SHALL run in ARM2.
REQ-031 Reaching TIMEOUT_CYCLES in ARM2 SHALL force an ACK2 pulse (keeping the PIC two-ack sequence aligned), set timeout_flag, and return to IDLE without asserting cpu_ready.
REQ-032 timeout_flag SHALL clear only on reset.
REQ-033 Without the macro, ARM2 SHALL wait indefinitely, timeout_flag SHALL be tied to 0, and no counter SHALL be synthesized.

Structure
REQ-034 The state enum and the ACK_WIDTH/TIMEOUT_CYCLES defaults SHALL live in shared package irem_pkg.
REQ-035 Pulse generation (high/low timing, done strobe) SHALL be sub-module irem_ack_pulse, instantiated once and reused for ACK1 and ACK2.

Verification
REQ-036 Scenario "normal": pic_int_req=1, pic_vector=8'h45, two INTA cycles -> cpu_intr, two 2-cycle ack pulses, cpu_vector=8'h45 with cpu_ready on both INTAs, return to IDLE.
REQ-037 Scenario "spurious": pic_int_req rises then falls before cpu_inta -> cpu_intr drops, pic_int_ack never pulses.
REQ-038 Scenario "late drop": pic_int_req falls after ACK1 -> vector still returned and exactly two ack pulses issued.
REQ-039 Scenario "reset mid-op": reset asserted in ACK2 -> all outputs 0 immediately; a fresh request afterwards completes normally.
REQ-040 Scenario "timeout" (macro on, TIMEOUT_CYCLES=16): no second INTA -> forced second pulse at cycle 16, timeout_flag=1, IDLE.
REQ-041 Scenario "ce gating": ce toggled 1-of-3 during normal scenario -> pulse widths counted in ce cycles, identical sequence.
